// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter, one digit per clock, most-significant first.
// Optional build macro BCD2BIN_CHECK_EN: digits >9 give err=1 and bin_out=0; otherwise raw nibbles are used and err=0.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = BIN_W + 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [4*DIGITS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [3:0]          nib_s;

  // acc*10 + digit at BIN_W+4 bits, truncated back to BIN_W
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc, input logic [3:0] nib);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] sum;
    ext = {4'b0000, acc};
    sum = (ext << 2'd3) + (ext << 2'd1) + {{BIN_W{1'b0}}, nib};
    return sum[BIN_W-1:0];
  endfunction

`ifdef BCD2BIN_CHECK_EN
  logic inv_q, inv_d;
  logic err_q, err_d;

  function automatic logic digit_invalid(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction
`endif

  assign nib_s = sh_q[4*DIGITS-1 -: 4];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CONV;
        else       state_d = IDLE;
      end
      CONV: begin
        if (cnt_q == LAST_CNT) state_d = IDLE;
        else                   state_d = CONV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    bin_d  = bin_q;
    busy_d = (state_d == CONV);
`ifdef BCD2BIN_CHECK_EN
    inv_d  = inv_q;
    err_d  = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d  = bcd_in;
          acc_d = {BIN_W{1'b0}};
          cnt_d = {CNT_W{1'b0}};
`ifdef BCD2BIN_CHECK_EN
          inv_d = 1'b0;
`endif
        end else begin
          sh_d = sh_q;
        end
      end
      CONV: begin
        acc_d = mac10(acc_q, nib_s);
        sh_d  = sh_q << 3'd4;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef BCD2BIN_CHECK_EN
        inv_d = inv_q | digit_invalid(nib_s);
`endif
        if (cnt_q == LAST_CNT) begin
          done_d = 1'b1;
`ifdef BCD2BIN_CHECK_EN
          if (inv_d) begin
            bin_d = {BIN_W{1'b0}};
            err_d = 1'b1;
          end else begin
            bin_d = acc_d;
            err_d = 1'b0;
          end
`else
          bin_d = acc_d;
`endif
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        acc_d = {BIN_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {BIN_W{1'b0}};
      sh_q   <= {(4*DIGITS){1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bin_q  <= {BIN_W{1'b0}};
`ifdef BCD2BIN_CHECK_EN
      inv_q  <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bin_q  <= bin_d;
`ifdef BCD2BIN_CHECK_EN
      inv_q  <= inv_d;
      err_q  <= err_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
`ifdef BCD2BIN_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14): vector table, handshake/reset sequences, random vs. model.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy, done, err;
  logic [13:0] bin_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: positional decimal value of the four nibbles, wrapped modulo 2^14
  function automatic void ref_conv(input logic [15:0] v, output logic [13:0] b, output logic e);
    int sum;
    int d;
    logic any_bad;
    sum = 0;
    any_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[4*i +: 4]);
      sum += d * (10 ** i);
`ifdef BCD2BIN_CHECK_EN
      if (d > 9) any_bad = 1'b1;
`endif
    end
    e = any_bad;
    b = any_bad ? 14'd0 : 14'(sum % 16384);
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask

  task automatic do_conv(input logic [15:0] v, output logic [13:0] b, output logic e, output int lat);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    wait_done(lat);
    b = bin_out;
    e = err;
    chk("busy_low_at_done", busy, 0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [13:0] b, eb;
    logic        e, ee;
    int          lat;
    int          ndone;
    logic [15:0] v;

    vecs[0] = '{16'h1234, 14'd1234, 1'b0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0};
    vecs[4] = '{16'h0001, 14'd1,    1'b0};
    vecs[5] = '{16'h0500, 14'd500,  1'b0};
`ifdef BCD2BIN_CHECK_EN
    vecs[3] = '{16'h12A4, 14'd0,    1'b1};
    vecs[6] = '{16'hFFFF, 14'd0,    1'b1};
    vecs[7] = '{16'h9A00, 14'd0,    1'b1};
`else
    vecs[3] = '{16'h12A4, 14'd1304, 1'b0};
    vecs[6] = '{16'hFFFF, 14'd281,  1'b0};
    vecs[7] = '{16'h9A00, 14'd10000, 1'b0};
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin",  bin_out, 0);
    chk("rst_err",  err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_conv(vecs[i].bcd, b, e, lat);
      chk("vec_bin", b, vecs[i].bin);
      chk("vec_err", e, vecs[i].err);
      chk("vec_latency", lat, 4);
      @(negedge clk);
      chk("vec_done_single", done, 0);
      chk("vec_bin_held", bin_out, vecs[i].bin);
    end

    // start held high through 0x0042; operand changes after acceptance
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0042;
    @(negedge clk);
    chk("hold_busy", busy, 1);
    bcd_in = 16'h0007;
    wait_done(lat);
    chk("hold_latency", lat, 4);
    chk("hold_bin", bin_out, 42);
    chk("hold_err", err, 0);
    // start still high in the done cycle: second conversion accepted at once
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done(lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_bin", bin_out, 7);

    // reset after two CONV edges of 0x5678
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bin",  bin_out, 0);
    chk("abort_err",  err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_conv(16'h0001, b, e, lat);
    chk("after_abort_bin", b, 1);
    chk("after_abort_latency", lat, 4);

    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        v = 16'h0000;
        for (int j = 0; j < 4; j++) v[4*j +: 4] = 4'($urandom_range(9, 0));
      end else begin
        v = 16'($urandom);
      end
      ref_conv(v, eb, ee);
      do_conv(v, b, e, lat);
      chk("rand_bin", b, eb);
      chk("rand_err", e, ee);
      chk("rand_latency", lat, 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
